// File: rtl/cpu_bus_initiator.sv
// Famicom CPU bus initiator: replays one queued command as M2/ROMSEL/RW/A/D bus cycles.
// Optional MMC1 serial write expansion is enabled by defining CPU_BUS_INITIATOR_MMC1_EN.
module cpu_bus_initiator #(
  parameter int M2_LOW_CLKS  = 4,
  parameter int M2_HIGH_CLKS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic        cmd_mmc1,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        m2,
  output logic        romsel,
  output logic        cpu_rw,
  output logic [14:0] cpu_addr,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_oe,
  input  logic [7:0]  cpu_data_in,
  output logic        busy
);

  localparam int MAXC = (M2_LOW_CLKS > M2_HIGH_CLKS) ? M2_LOW_CLKS : M2_HIGH_CLKS;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] LOW_LD  = CW'(M2_LOW_CLKS - 1);
  localparam logic [CW-1:0] HIGH_LD = CW'(M2_HIGH_CLKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_HOLD} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          a15_q;
  logic          m2_q, romsel_q, rw_q, oe_q, ready_q, busy_q, rsp_valid_q;
  logic [14:0]   addr_q;
  logic [7:0]    dout_q, rsp_data_q;
  logic [7:0]    beat0_d;

`ifdef CPU_BUS_INITIATOR_MMC1_EN
  logic [2:0]    beats_q;
  logic [3:0]    sh_q;
  logic          serial_d;
  assign serial_d = cmd_mmc1 & ~cmd_rw & ~cmd_data[7];
  // bit 7 set means an MMC1 shift-register reset, always sent as a single 8'h80 beat
  assign beat0_d  = serial_d ? {7'b0, cmd_data[0]} :
                    (cmd_mmc1 & ~cmd_rw) ? 8'h80 : cmd_data;
`else
  logic          mmc1_unused;
  assign mmc1_unused = cmd_mmc1;
  assign beat0_d     = cmd_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a15_q       <= 1'b0;
      m2_q        <= 1'b0;
      romsel_q    <= 1'b1;
      rw_q        <= 1'b1;
      oe_q        <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      addr_q      <= '0;
      dout_q      <= '0;
      rsp_data_q  <= '0;
`ifdef CPU_BUS_INITIATOR_MMC1_EN
      beats_q     <= '0;
      sh_q        <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            state_q <= S_LOW;
            cnt_q   <= LOW_LD;
            a15_q   <= cmd_addr[15];
            addr_q  <= cmd_addr[14:0];
            rw_q    <= cmd_rw;
            oe_q    <= ~cmd_rw;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (!cmd_rw) dout_q <= beat0_d;
`ifdef CPU_BUS_INITIATOR_MMC1_EN
            beats_q <= serial_d ? 3'd4 : 3'd0;
            sh_q    <= cmd_data[4:1];
`endif
          end
        end
        S_LOW: begin
          if (cnt_q == '0) begin
            state_q  <= S_HIGH;
            cnt_q    <= HIGH_LD;
            m2_q     <= 1'b1;
            romsel_q <= ~a15_q;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_HIGH: begin
          if (cnt_q == '0) begin
            state_q  <= S_HOLD;
            m2_q     <= 1'b0;
            romsel_q <= 1'b1;
            if (rw_q) begin
              rsp_data_q  <= cpu_data_in;
              rsp_valid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_HOLD: begin
`ifdef CPU_BUS_INITIATOR_MMC1_EN
          if (beats_q != 3'd0) begin
            state_q <= S_LOW;
            cnt_q   <= LOW_LD;
            beats_q <= beats_q - 3'd1;
            dout_q  <= {7'b0, sh_q[0]};
            sh_q    <= {1'b0, sh_q[3:1]};
          end else
`endif
          begin
            state_q <= S_IDLE;
            rw_q    <= 1'b1;
            oe_q    <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready    = ready_q;
  assign busy         = busy_q;
  assign m2           = m2_q;
  assign romsel       = romsel_q;
  assign cpu_rw       = rw_q;
  assign cpu_addr     = addr_q;
  assign cpu_data_out = dout_q;
  assign cpu_data_oe  = oe_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;

endmodule

// File: tb/tb_cpu_bus_initiator.sv
// Directed bench for cpu_bus_initiator; expected bus beats and read data go through scoreboard queues.
module tb_cpu_bus_initiator;
  localparam int L = 4;
  localparam int H = 4;

  typedef struct {
    logic        rw;
    logic [14:0] addr;
    logic [7:0]  data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid = 1'b0, cmd_rw = 1'b1, cmd_mmc1 = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [7:0]  cmd_data = '0, cpu_data_in = '0;
  logic        cmd_ready, rsp_valid, m2, romsel, cpu_rw, cpu_data_oe, busy;
  logic [7:0]  rsp_data, cpu_data_out;
  logic [14:0] cpu_addr;

  int total = 0, bad = 0;
  int beats_seen = 0, rsp_seen = 0;
  beat_t exp_q[$];
  logic [7:0] rsp_q[$];
  beat_t mon_e;
  logic [7:0] mon_d;
  logic prev_m2 = 1'b0;
  logic cur_a15 = 1'b0;

  cpu_bus_initiator #(.M2_LOW_CLKS(L), .M2_HIGH_CLKS(H)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw), .cmd_mmc1(cmd_mmc1),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .m2(m2), .romsel(romsel), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_data_out(cpu_data_out), .cpu_data_oe(cpu_data_oe), .cpu_data_in(cpu_data_in),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    if (o !== e) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // bus monitor: one beat completes at each m2 falling edge; read data appears in HOLD
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_m2 = 1'b0;
    end else begin
      chk("romsel", romsel, !(cur_a15 && m2));
      if (cmd_ready) chk("m2_in_idle", m2, 1'b0);
      if (prev_m2 && !m2) begin
        beats_seen++;
        chk("beat_pending", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("beat_rw", cpu_rw, mon_e.rw);
          chk("beat_addr", cpu_addr, mon_e.addr);
          chk("beat_oe", cpu_data_oe, !mon_e.rw);
          if (!mon_e.rw) chk("beat_data", cpu_data_out, mon_e.data);
        end
      end
      if (rsp_valid) begin
        rsp_seen++;
        chk("rsp_pending", rsp_q.size() > 0, 1'b1);
        if (rsp_q.size() > 0) begin
          mon_d = rsp_q.pop_front();
          chk("rsp_data", rsp_data, mon_d);
        end
        chk("rsp_in_hold", m2, 1'b0);
      end
      prev_m2 = m2;
    end
  end

  task automatic model(input logic rw, input logic mmc1, input logic [15:0] a, input logic [7:0] d,
                       output int nb, output logic [7:0] d0);
    beat_t e;
    e.rw = rw;
    e.addr = a[14:0];
    nb = 1;
`ifdef CPU_BUS_INITIATOR_MMC1_EN
    if (mmc1 && !rw && !d[7]) begin
      for (int k = 0; k < 5; k++) begin
        e.data = {7'b0, d[k]};
        exp_q.push_back(e);
      end
      nb = 5;
      d0 = {7'b0, d[0]};
    end else begin
      e.data = (mmc1 && !rw) ? 8'h80 : d;
      exp_q.push_back(e);
      d0 = e.data;
    end
`else
    e.data = d;
    exp_q.push_back(e);
    d0 = mmc1 ? d : e.data;
`endif
    if (rw) rsp_q.push_back(cpu_data_in);
  endtask

  task automatic do_cmd(input logic rw, input logic mmc1, input logic [15:0] a, input logic [7:0] d);
    int nb, n, high, first_hi;
    logic [7:0] d0;
    model(rw, mmc1, a, d, nb, d0);
    @(negedge clk);
    cur_a15 = a[15];
    cmd_rw = rw; cmd_mmc1 = mmc1; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_data = ~d; cmd_rw = ~rw; cmd_addr = {a[15], ~a[14:0]};
    n = 0; high = 0; first_hi = -1;
    while (n < 400) begin
      @(negedge clk);
      if (cmd_ready) break;
      if (n == 0) begin
        chk("low_rw", cpu_rw, rw);
        chk("low_addr", cpu_addr, a[14:0]);
        chk("low_oe", cpu_data_oe, !rw);
        chk("low_busy", busy, 1'b1);
        if (!rw) chk("low_data", cpu_data_out, d0);
      end
      if (m2) begin
        high++;
        if (first_hi < 0) first_hi = n;
      end
      n++;
    end
    chk("busy_clks", n, nb * (L + H + 1));
    chk("m2_high_clks", high, nb * H);
    chk("m2_rise_at", first_hi, L);
    chk("idle_busy", busy, 1'b0);
    chk("beats_left", exp_q.size(), 0);
  endtask

  initial begin
    int n, r0, b0, b1, rises, target;
    logic pm;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_m2", m2, 1'b0);
    chk("rst_romsel", romsel, 1'b1);
    chk("rst_rw", cpu_rw, 1'b1);
    chk("rst_addr", cpu_addr, 15'h0);
    chk("rst_dout", cpu_data_out, 8'h00);
    chk("rst_oe", cpu_data_oe, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    do_cmd(1'b0, 1'b0, 16'h5006, 8'h01);

    cpu_data_in = 8'hA5;
    r0 = rsp_seen;
    do_cmd(1'b1, 1'b0, 16'h8000, 8'h00);
    chk("rd_rsp_count", rsp_seen, r0 + 1);
    chk("rd_rsp_data", rsp_data, 8'hA5);

    do_cmd(1'b0, 1'b1, 16'hE000, 8'h0D);
    do_cmd(1'b0, 1'b1, 16'h8000, 8'h80);
    do_cmd(1'b0, 1'b1, 16'hA000, 8'hFF);
    cpu_data_in = 8'h5A;
    do_cmd(1'b1, 1'b1, 16'hC000, 8'h0D);
    chk("mmc1_rd_data", rsp_data, 8'h5A);

    // back-to-back: valid stays high across two commands
    begin
      int nb;
      logic [7:0] d0;
      cpu_data_in = 8'h3C;
      model(1'b0, 1'b0, 16'h8001, 8'h11, nb, d0);
      model(1'b1, 1'b0, 16'hC002, 8'h00, nb, d0);
      @(negedge clk);
      cur_a15 = 1'b1;
      cmd_rw = 1'b0; cmd_mmc1 = 1'b0; cmd_addr = 16'h8001; cmd_data = 8'h11; cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_rw = 1'b1; cmd_addr = 16'hC002; cmd_data = 8'h00;
      n = 0;
      while (n < 100) begin
        @(negedge clk);
        if (cmd_ready) break;
        n++;
      end
      chk("b2b_first_clks", n, L + H + 1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      chk("b2b_one_idle", cmd_ready, 1'b0);
      chk("b2b_low_m2", m2, 1'b0);
      chk("b2b_low_rw", cpu_rw, 1'b1);
      n = 1;
      while (n < 100) begin
        @(negedge clk);
        if (cmd_ready) break;
        n++;
      end
      chk("b2b_second_clks", n, L + H + 1);
      chk("b2b_beats_left", exp_q.size(), 0);
      chk("b2b_rsp", rsp_data, 8'h3C);
    end

    // reset during HIGH of a later beat
    begin
      int nb;
      logic [7:0] d0;
`ifdef CPU_BUS_INITIATOR_MMC1_EN
      target = 2;
      model(1'b0, 1'b1, 16'hE000, 8'h0D, nb, d0);
      cmd_mmc1 = 1'b1; cmd_addr = 16'hE000; cmd_data = 8'h0D;
`else
      target = 1;
      model(1'b0, 1'b0, 16'h8000, 8'h55, nb, d0);
      cmd_mmc1 = 1'b0; cmd_addr = 16'h8000; cmd_data = 8'h55;
`endif
      b0 = beats_seen;
      @(negedge clk);
      cur_a15 = 1'b1;
      cmd_rw = 1'b0; cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      rises = 0; pm = 1'b0; n = 0;
      while (n < 200) begin
        @(negedge clk);
        if (m2 && !pm) rises++;
        pm = m2;
        if (rises == target) break;
        n++;
      end
      chk("rst_reached_high", m2, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_m2", m2, 1'b0);
      chk("midrst_romsel", romsel, 1'b1);
      chk("midrst_rw", cpu_rw, 1'b1);
      chk("midrst_oe", cpu_data_oe, 1'b0);
      chk("midrst_ready", cmd_ready, 1'b1);
      chk("midrst_beats_done", beats_seen - b0, target - 1);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      b1 = beats_seen;
      repeat (40) @(negedge clk);
      chk("postrst_no_beats", beats_seen, b1);
      chk("postrst_ready", cmd_ready, 1'b1);
      chk("postrst_busy", busy, 1'b0);
    end

    do_cmd(1'b0, 1'b0, 16'h5001, 8'hC3);
    chk("rsp_data_held", rsp_data, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
